maxpool_seq: RTL

Streaming max-pool sequencer for the TPU vector path. Accepts IEEE-754 fp32 elements on a valid/ready stream and reduces each window of cfg_len elements to a single maximum. Uses the existing combinational fp32 `max` unit as its only comparator, and sequences one comparison per accepted element. Sits between the activation output stream and the pooling writeback buffer.

---
 rtl/maxpool_seq_pkg.sv | 24 ++
 rtl/maxpool_seq_max.sv | 21 ++
 rtl/maxpool_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/maxpool_seq_pkg.sv
// Shared fp32 types, sequencer state encoding and ordering helpers for the TPU vector path.
package tpu_pkg;

   typedef logic [31:0] fp32_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } maxpool_state_t;

   localparam fp32_t FP32_NEG_INF = 32'hFF80_0000;
   localparam fp32_t FP32_ZERO    = 32'h0000_0000;

   function automatic logic fp32_is_nan(input fp32_t x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Maps sign-magnitude fp32 onto an unsigned key so that -0 < +0 and -inf is smallest.
   function automatic logic [31:0] fp32_key(input fp32_t x);
      return x[31] ? ~x : (x | 32'h8000_0000);
   endfunction

endpackage

// File: rtl/maxpool_seq_max.sv
// Combinational fp32 max: NaN on either side propagates (inputA first); on equality inputA is returned.
module max
   import tpu_pkg::*;
(
   input  fp32_t inputA,
   input  fp32_t inputB,
   output fp32_t result
);

   always_comb begin
      if (fp32_is_nan(inputA))
         result = inputA;
      else if (fp32_is_nan(inputB))
         result = inputB;
      else if (fp32_key(inputB) > fp32_key(inputA))
         result = inputB;
      else
         result = inputA;
   end

endmodule

// File: rtl/maxpool_seq.sv
// Streaming fp32 max-pool sequencer: one comparison per accepted element, one result per window.
// Define MAXPOOL_ARGMAX_EN to add the out_idx port reporting the winning element position.
//
// state  | meaning
// IDLE   | one dead cycle after reset release, in_ready low
// ACCUM  | accepting elements, folding each into acc
// OUTPUT | holding the window maximum until out_ready
module maxpool_seq
   import tpu_pkg::*;
#(
   parameter int LEN_W  = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic [LEN_W-1:0]  count
`ifdef MAXPOOL_ARGMAX_EN
   ,
   output logic [LEN_W-1:0]  out_idx
`endif
);

   maxpool_state_t   state;
   fp32_t            acc;
   fp32_t            max_out;
   fp32_t            acc_nxt;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_eff;
   logic [LEN_W-1:0] cnt_nxt;
   logic             first;
   logic             last;
   logic             accept;

   max u_max (
      .inputA (acc),
      .inputB (in_data),
      .result (max_out)
   );

   assign accept = in_valid && in_ready;

   always_comb begin
      len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      first   = (count == '0);
      acc_nxt = first ? in_data : max_out;
      cnt_nxt = count + LEN_W'(1);
      last    = first ? (len_eff == LEN_W'(1)) : (cnt_nxt == len_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= FP32_ZERO;
         count     <= '0;
         len_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= FP32_ZERO;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= ACCUM;
               in_ready <= 1'b1;
            end
            ACCUM: begin
               if (accept) begin
                  acc   <= acc_nxt;
                  count <= cnt_nxt;
                  busy  <= 1'b1;
                  if (first)
                     len_q <= len_eff;
                  if (last) begin
                     state     <= OUTPUT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_data  <= acc_nxt;
                  end
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  count     <= '0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef MAXPOOL_ARGMAX_EN
   // A later element takes the index only if it strictly beats acc, so ties keep the earlier one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out_idx <= '0;
      else if (state == ACCUM && accept) begin
         if (first)
            out_idx <= '0;
         else if (max_out != acc)
            out_idx <= count;
      end
   end
`endif

endmodule
